// File: rtl/ofm_writeback_packer_if.sv
// Pixel stream plus global-BRAM write bus for the OFM write-back packer.
//   pixel_valid/pixel_data/pixel_ready : fused-block pixel stream into the packer
//   we_global/wr_addr_global/wr_data_global/bram_ready : packed word writes out
// master = packer side, slave = environment (fused block + BRAM) side.
interface ofm_writeback_packer_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 16
);
  logic                   pixel_valid;
  logic [PIX_W-1:0]       pixel_data;
  logic                   pixel_ready;
  logic                   we_global;
  logic [31:0]            wr_addr_global;
  logic [PIX_W*LANES-1:0] wr_data_global;
  logic                   bram_ready;

  modport master (
    input  pixel_valid, pixel_data, bram_ready,
    output pixel_ready, we_global, wr_addr_global, wr_data_global
  );
  modport slave (
    output pixel_valid, pixel_data, bram_ready,
    input  pixel_ready, we_global, wr_addr_global, wr_data_global
  );
endinterface

// File: rtl/ofm_writeback_packer.sv
// OFM write-back packer: gathers LANES pixels of PIX_W bits into one global
// BRAM word, queues words in a 2-entry FIFO and writes them at consecutive
// 16-byte addresses starting at base_addr_OFM.
//   clk, reset_n       : clock, async active-low reset
//   start              : job start pulse (IDLE only)
//   base_addr_OFM      : byte address of first word (sampled on start)
//   size_OFM           : pixel count of the job (sampled on start)
//   busy, done         : job in progress / one-cycle completion pulse
//   bus (master)       : pixel stream in, BRAM write bus out

// One pixel lane of the word buffer. o is the lane value as it will be
// pushed this cycle (the incoming pixel bypasses the register when loaded).
module ofm_wb_lane #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] o
);
  logic [PIX_W-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (ld)   q <= din;
  end

  assign o = ld ? din : q;
endmodule

module ofm_writeback_packer #(
  parameter int PIX_W = 8,
  parameter int LANES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [31:0]                  base_addr_OFM,
  input  logic [31:0]                  size_OFM,
  output logic                         busy,
  output logic                         done,
  ofm_writeback_packer_if.master       bus
);
  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW  = PIX_W * LANES;

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]    size_q, pix_cnt, next_addr;
  logic [LIW-1:0] lane_idx;
  logic [1:0]     fcnt;
  logic           wp, rp;
  logic [1:0][31:0]   faddr;
  logic [1:0][WW-1:0] fdata;

  logic start_acc, accept, last, full, push, pop;
  logic [LANES-1:0][PIX_W-1:0] word_nx;

  assign start_acc = (state == IDLE) && start;
  assign accept    = bus.pixel_valid && bus.pixel_ready;
  assign last      = (pix_cnt + 32'd1) == size_q;
  assign full      = lane_idx == LIW'(LANES - 1);
  assign push      = accept && (last || full);
  assign pop       = (fcnt != 2'd0) && bus.bram_ready;

  // Lane buffer: clearing on every push leaves the unfilled lanes of a
  // partial last word at zero without extra masking.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ofm_wb_lane #(.PIX_W(PIX_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start_acc || push),
      .ld      (accept && (lane_idx == LIW'(l))),
      .din     (bus.pixel_data),
      .o       (word_nx[l])
    );
  end

  // Job counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q    <= '0;
      pix_cnt   <= '0;
      lane_idx  <= '0;
      next_addr <= '0;
    end else if (start_acc) begin
      size_q    <= size_OFM;
      pix_cnt   <= '0;
      lane_idx  <= '0;
      next_addr <= base_addr_OFM;
    end else if (accept) begin
      pix_cnt  <= pix_cnt + 32'd1;
      lane_idx <= full ? '0 : lane_idx + LIW'(1);
      if (push) next_addr <= next_addr + 32'd16;
    end
  end

  // 2-entry output FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt  <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      faddr <= '0;
      fdata <= '0;
    end else begin
      if (push) begin
        faddr[wp] <= next_addr;
        fdata[wp] <= word_nx;
        wp        <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 2'd1;
        2'b01:   fcnt <= fcnt - 2'd1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Head is forced to zero when empty so an idle bus never shows stale words.
  assign bus.we_global      = fcnt != 2'd0;
  assign bus.wr_addr_global = bus.we_global ? faddr[rp] : '0;
  assign bus.wr_data_global = bus.we_global ? fdata[rp] : '0;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (size_OFM != 32'd0) ? PACK : DRAIN;
      PACK:  if (push && last) state_nx = DRAIN;
      DRAIN: if (fcnt == 2'd0) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy            = state != IDLE;
    done            = state == DONE;
    bus.pixel_ready = (state == PACK) && (fcnt < 2'd2);
  end
endmodule

// File: tb/tb_ofm_writeback_packer.sv
module tb_ofm_writeback_packer;
  logic        clk = 1'b0;
  logic        reset_n, start, busy, done;
  logic [31:0] base_addr_OFM, size_OFM;
  int total = 0, bad = 0, done_cnt = 0;
  logic [31:0]  wa[$];
  logic [127:0] wd[$];

  ofm_writeback_packer_if #(.PIX_W(8), .LANES(16)) bus ();

  ofm_writeback_packer #(.PIX_W(8), .LANES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr_OFM(base_addr_OFM), .size_OFM(size_OFM),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // write/done monitor on the falling edge, where everything is settled
  always @(negedge clk) begin
    if (bus.we_global && bus.bram_ready) begin
      wa.push_back(bus.wr_addr_global);
      wd.push_back(bus.wr_data_global);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_word(input int first, input int cnt);
    logic [127:0] w = '0;
    for (int k = 0; k < 16; k++) if (k < cnt) w[k*8 +: 8] = 8'(first + k);
    return w;
  endfunction

  function automatic logic [31:0] get_a(input int i);
    return (i < wa.size()) ? wa[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [127:0] get_d(input int i);
    return (i < wd.size()) ? wd[i] : {128{1'bx}};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); done_cnt = 0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] s);
    base_addr_OFM = b; size_OFM = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // offer pixels first, first+1, ... for up to maxcyc cycles or n accepts
  task automatic feed(input int n, input int first, input int maxcyc, output int sent);
    int v = first, c = 0;
    logic acc;
    sent = 0;
    while (sent < n && c < maxcyc) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = 8'(v);
      acc = bus.pixel_ready;
      step();
      if (acc) begin sent++; v++; end
      c++;
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy && g < 200) begin step(); g++; end
    step();
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int sent, bc;
    reset_n = 1'b0; start = 1'b0; base_addr_OFM = '0; size_OFM = '0;
    bus.pixel_valid = 1'b0; bus.pixel_data = '0; bus.bram_ready = 1'b1;
    repeat (3) step();
    check("rst_ready", bus.pixel_ready, 1'b0);
    check("rst_we",    bus.we_global, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_addr",  bus.wr_addr_global, 32'h0);
    check("rst_data",  bus.wr_data_global, 128'h0);
    reset_n = 1'b1;
    step();

    // two full words, continuous pixels
    clear_log();
    do_start(32'h1000, 32);
    check("t1_busy", busy, 1'b1);
    feed(32, 0, 100, sent);
    wait_idle("t1");
    check("t1_sent", sent, 32);
    check("t1_nw", wa.size(), 2);
    check("t1_a0", get_a(0), 32'h1000);
    check("t1_d0", get_d(0), 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_a1", get_a(1), 32'h1010);
    check("t1_d1", get_d(1), 128'h1F1E1D1C1B1A19181716151413121110);
    check("t1_done", done_cnt, 1);

    // partial last word
    clear_log();
    do_start(32'h2000, 20);
    feed(20, 1, 100, sent);
    wait_idle("t2");
    check("t2_nw", wa.size(), 2);
    check("t2_a0", get_a(0), 32'h2000);
    check("t2_d0", get_d(0), mk_word(1, 16));
    check("t2_a1", get_a(1), 32'h2010);
    check("t2_d1", get_d(1), 128'h00000000_00000000_00000000_14131211);
    check("t2_done", done_cnt, 1);

    // backpressure: FIFO fills, head held
    clear_log();
    bus.bram_ready = 1'b0;
    do_start(32'h3000, 48);
    feed(48, 0, 20, sent);
    check("t3_sent_a", sent, 20);
    check("t3_head_a", bus.wr_addr_global, 32'h3000);
    check("t3_hdat_a", bus.wr_data_global, mk_word(0, 16));
    feed(28, 20, 20, sent);
    check("t3_sent_b", sent, 12);
    check("t3_ready", bus.pixel_ready, 1'b0);
    check("t3_we", bus.we_global, 1'b1);
    check("t3_head_b", bus.wr_addr_global, 32'h3000);
    check("t3_hdat_b", bus.wr_data_global, mk_word(0, 16));
    check("t3_nw_stall", wa.size(), 0);
    bus.bram_ready = 1'b1;
    feed(16, 32, 100, sent);
    wait_idle("t3");
    check("t3_sent_c", sent, 16);
    check("t3_nw", wa.size(), 3);
    check("t3_a0", get_a(0), 32'h3000);
    check("t3_d0", get_d(0), mk_word(0, 16));
    check("t3_a1", get_a(1), 32'h3010);
    check("t3_d1", get_d(1), mk_word(16, 16));
    check("t3_a2", get_a(2), 32'h3020);
    check("t3_d2", get_d(2), mk_word(32, 16));

    // empty job
    clear_log();
    base_addr_OFM = 32'h4000; size_OFM = 0; start = 1'b1;
    step();
    start = 1'b0;
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bc++;
      step();
    end
    check("t4_busy_cyc", bc, 2);
    check("t4_nw", wa.size(), 0);
    check("t4_done", done_cnt, 1);

    // reset mid-job
    clear_log();
    do_start(32'h4000, 32);
    feed(10, 8'h50, 100, sent);
    reset_n = 1'b0;
    #1;
    check("t5_we", bus.we_global, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", bus.pixel_ready, 1'b0);
    check("t5_addr", bus.wr_addr_global, 32'h0);
    check("t5_data", bus.wr_data_global, 128'h0);
    step();
    reset_n = 1'b1;
    step();
    check("t5_nw_rst", wa.size(), 0);
    clear_log();
    do_start(32'h5000, 16);
    feed(16, 8'hA0, 100, sent);
    wait_idle("t5");
    check("t5_nw", wa.size(), 1);
    check("t5_a0", get_a(0), 32'h5000);
    check("t5_d0", get_d(0), mk_word(8'hA0, 16));

    // second start ignored, extra pixels not taken
    clear_log();
    do_start(32'h6000, 20);
    feed(5, 0, 100, sent);
    do_start(32'h7000, 5);
    feed(40, 5, 40, sent);
    check("t6_sent", sent, 15);
    wait_idle("t6");
    check("t6_nw", wa.size(), 2);
    check("t6_a0", get_a(0), 32'h6000);
    check("t6_a1", get_a(1), 32'h6010);
    check("t6_d1", get_d(1), mk_word(16, 4));
    check("t6_done", done_cnt, 1);

    // address wraps at 32 bits
    clear_log();
    do_start(32'hFFFF_FFF0, 20);
    feed(20, 0, 100, sent);
    wait_idle("t7");
    check("t7_a0", get_a(0), 32'hFFFF_FFF0);
    check("t7_a1", get_a(1), 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
